// File: rtl/vga_term_pkg.sv
// Shared types and constants for the VGA text-terminal controller and its display-side helpers.
package vga_term_pkg;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } term_state_t;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  localparam int         DEF_COLS  = 70;
  localparam int         DEF_ROWS  = 30;
  localparam logic [7:0] DEF_BLANK = 8'h20;

endpackage

// File: rtl/vga_row_map.sv
// (a + b) mod ROWS for the circular row buffer; both operands are already below ROWS.
module vga_row_map
  import vga_term_pkg::*;
#(
  parameter int ROWS = DEF_ROWS
) (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] y
);

  logic [5:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 6'(ROWS)) y = 5'(sum - 6'(ROWS));
    else                 y = sum[4:0];
  end

endmodule

// File: rtl/vga_term_ctrl.sv
// Text-terminal controller: turns an ASCII stream into one-cell video-memory writes,
// tracking the cursor and scrolling via a circular row offset (top_row).
module vga_term_ctrl
  import vga_term_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = DEF_BLANK
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic       wr_en,
  output logic [6:0] wr_x,
  output logic [4:0] wr_y,
  output logic [7:0] wr_data,
  output logic [4:0] top_row,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);

  localparam int            CELLS     = COLS * ROWS;
  localparam int            CW        = $clog2(CELLS);
  localparam logic [6:0]    X_MAX     = 7'(COLS - 1);
  localparam logic [4:0]    Y_MAX     = 5'(ROWS - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(CELLS - 1);

  // Handshake: a character is taken on any rising edge where ch_valid && ch_ready;
  // the source must hold ch_data stable while ch_valid is high and ch_ready is low.
  term_state_t   state, state_n;
  logic [CW-1:0] clr_cnt, clr_cnt_n;
  logic [6:0]    clr_x, clr_x_n;
  logic [4:0]    clr_y, clr_y_n;
  logic [4:0]    clear_row, clear_row_n;
  logic [6:0]    cur_x_n, wr_x_n;
  logic [4:0]    cur_y_n, top_row_n, wr_y_n;
  logic [7:0]    wr_data_n;
  logic          wr_en_n, do_nl;
  logic [4:0]    phys;

  vga_row_map #(.ROWS(ROWS)) u_phys (.a(top_row), .b(cur_y), .y(phys));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state     <= CLR_ALL;
      clr_cnt   <= '0;
      clr_x     <= '0;
      clr_y     <= '0;
      clear_row <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      top_row   <= '0;
      wr_en     <= 1'b0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_data   <= '0;
      ch_ready  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_n;
      clr_cnt   <= clr_cnt_n;
      clr_x     <= clr_x_n;
      clr_y     <= clr_y_n;
      clear_row <= clear_row_n;
      cur_x     <= cur_x_n;
      cur_y     <= cur_y_n;
      top_row   <= top_row_n;
      wr_en     <= wr_en_n;
      wr_x      <= wr_x_n;
      wr_y      <= wr_y_n;
      wr_data   <= wr_data_n;
      ch_ready  <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    clr_cnt_n   = clr_cnt;
    clr_x_n     = clr_x;
    clr_y_n     = clr_y;
    clear_row_n = clear_row;
    cur_x_n     = cur_x;
    cur_y_n     = cur_y;
    top_row_n   = top_row;
    wr_en_n     = 1'b0;
    wr_x_n      = wr_x;
    wr_y_n      = wr_y;
    wr_data_n   = wr_data;
    do_nl       = 1'b0;

    case (state)
      CLR_ALL: begin
        wr_en_n   = 1'b1;
        wr_x_n    = clr_x;
        wr_y_n    = clr_y;
        wr_data_n = BLANK;
        if (clr_cnt == CELL_LAST) begin
          clr_cnt_n = '0;
          clr_x_n   = '0;
          clr_y_n   = '0;
          state_n   = IDLE;
        end else begin
          clr_cnt_n = clr_cnt + CW'(1);
          if (clr_x == X_MAX) begin
            clr_x_n = '0;
            clr_y_n = clr_y + 5'd1;
          end else begin
            clr_x_n = clr_x + 7'd1;
          end
        end
      end

      CLR_ROW: begin
        wr_en_n   = 1'b1;
        wr_x_n    = clr_x;
        wr_y_n    = clear_row;
        wr_data_n = BLANK;
        if (clr_x == X_MAX) begin
          clr_x_n = '0;
          state_n = IDLE;
        end else begin
          clr_x_n = clr_x + 7'd1;
        end
      end

      IDLE: begin
        if (ch_valid && ch_ready) begin
          if (ch_data >= CH_PRINT_LO && ch_data <= CH_PRINT_HI) begin
            wr_en_n   = 1'b1;
            wr_x_n    = cur_x;
            wr_y_n    = phys;
            wr_data_n = ch_data;
            if (cur_x == X_MAX) begin
              cur_x_n = '0;
              do_nl   = 1'b1;
            end else begin
              cur_x_n = cur_x + 7'd1;
            end
          end else begin
            case (ch_data)
              CH_LF: begin
                cur_x_n = '0;
                do_nl   = 1'b1;
              end
              CH_CR: cur_x_n = '0;
              CH_BS: begin
                if (cur_x != 7'd0) begin
                  cur_x_n   = cur_x - 7'd1;
                  wr_en_n   = 1'b1;
                  wr_x_n    = cur_x - 7'd1;
                  wr_y_n    = phys;
                  wr_data_n = BLANK;
                end
              end
              CH_FF: begin
                cur_x_n   = '0;
                cur_y_n   = '0;
                top_row_n = '0;
                state_n   = CLR_ALL;
              end
              default: ;
            endcase
          end

          // Scrolling reuses the old top row as the new bottom row, so it is blanked.
          if (do_nl) begin
            if (cur_y == Y_MAX) begin
              clear_row_n = top_row;
              top_row_n   = (top_row == Y_MAX) ? 5'd0 : top_row + 5'd1;
              state_n     = CLR_ROW;
            end else begin
              cur_y_n = cur_y + 5'd1;
            end
          end
        end
      end

      default: state_n = CLR_ALL;
    endcase
  end

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl: expected cell writes are queued by the stimulus and
// consumed by an independent write monitor; cursor/offset state is checked between steps.
module tb_vga_term_ctrl;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic       pclk;
  logic       reset;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;
  logic       wr_en;
  logic [6:0] wr_x;
  logic [4:0] wr_y;
  logic [7:0] wr_data;
  logic [4:0] top_row;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  vga_term_ctrl dut (
    .pclk    (pclk),
    .reset   (reset),
    .ch_valid(ch_valid),
    .ch_data (ch_data),
    .ch_ready(ch_ready),
    .wr_en   (wr_en),
    .wr_x    (wr_x),
    .wr_y    (wr_y),
    .wr_data (wr_data),
    .top_row (top_row),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .busy    (busy)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push(input int x, input int y, input logic [7:0] d);
    exp_q.push_back({7'(x), 5'(y), d});
  endfunction

  function automatic void push_blank_all();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        push(x, y, 8'h20);
  endfunction

  // scoreboard monitor: every write strobe must match the head of the expected queue
  always @(negedge pclk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got x=%0d y=%0d d=0x%0h expected no write",
                 wr_x, wr_y, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_cell{x,y,d}", {12'd0, wr_x, wr_y, wr_data}, {12'd0, mon_e});
      end
    end
  end

  // driver tasks: all stimulus changes land 1 time unit after a falling edge
  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, output int waited);
    ch_valid = 1'b1;
    ch_data  = c;
    waited   = 0;
    while (!ch_ready && waited < 5000) begin
      step();
      waited++;
    end
    if (!ch_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ch_ready=0 after %0d cycles expected 1", waited);
    end
    step();
  endtask

  task automatic send_idle(input logic [7:0] c);
    int w;
    send_char(c, w);
    ch_valid = 1'b0;
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      step();
      cyc++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_wr_en",    wr_en,    0);
    chk("rst_wr_x",     wr_x,     0);
    chk("rst_wr_y",     wr_y,     0);
    chk("rst_wr_data",  wr_data,  0);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_busy",     busy,     1);
    chk("rst_cur_x",    cur_x,    0);
    chk("rst_cur_y",    cur_y,    0);
    chk("rst_top_row",  top_row,  0);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int w;
    reset    = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    repeat (3) step();

    // 1: power-up clear of the whole grid
    check_reset_vals();
    push_blank_all();
    reset = 1'b0;
    wait_drain(cyc);
    chk("clr_all_cycles", cyc, 2100);
    chk("post_clr_ready", ch_ready, 1);
    chk("post_clr_busy",  busy,     0);
    chk("post_clr_cur_x", cur_x,    0);
    chk("post_clr_cur_y", cur_y,    0);
    chk("post_clr_top",   top_row,  0);

    // 2: back-to-back printable characters
    push(0, 0, 8'h41);
    push(1, 0, 8'h42);
    send_char(8'h41, w);
    send_char(8'h42, w);
    ch_valid = 1'b0;
    wait_drain(cyc);
    chk("ab_cur_x", cur_x, 2);
    chk("ab_cur_y", cur_y, 0);

    // 3: line wrap after the last column
    send_idle(8'h0D);
    chk("cr_cur_x", cur_x, 0);
    for (int i = 0; i < COLS; i++) push(i, 0, 8'h78);
    push(0, 1, 8'h78);
    for (int i = 0; i < COLS + 1; i++) send_char(8'h78, w);
    ch_valid = 1'b0;
    wait_drain(cyc);
    chk("wrap_cur_x", cur_x, 1);
    chk("wrap_cur_y", cur_y, 1);

    // 4: scroll from the bottom row, with the next character held while busy
    for (int i = 0; i < ROWS - 2; i++) send_idle(8'h0A);
    chk("lf_cur_y", cur_y, ROWS - 1);
    chk("lf_cur_x", cur_x, 0);
    for (int i = 0; i < COLS; i++) push(i, 0, 8'h20);
    push(0, 0, 8'h5A);
    send_char(8'h0A, w);
    chk("scroll_busy", busy, 1);
    send_char(8'h5A, w);
    chk("scroll_ready_low", w, COLS);
    ch_valid = 1'b0;
    wait_drain(cyc);
    chk("scroll_top", top_row, 1);
    chk("scroll_cur_y", cur_y, ROWS - 1);
    chk("scroll_cur_x", cur_x, 1);

    // 5: backspace at column 0, backspace mid-line, ignored control code
    send_idle(8'h0D);
    send_idle(8'h08);
    repeat (3) step();
    chk("bs0_cur_x", cur_x, 0);
    chk("bs0_cur_y", cur_y, ROWS - 1);
    for (int i = 0; i < 5; i++) push(i, 0, 8'h61 + 8'(i));
    push(4, 0, 8'h20);
    for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i), w);
    chk("pre_bs_cur_x", cur_x, 5);
    send_char(8'h08, w);
    send_char(8'h07, w);
    ch_valid = 1'b0;
    wait_drain(cyc);
    repeat (3) step();
    chk("bs_cur_x", cur_x, 4);
    chk("bel_cur_y", cur_y, ROWS - 1);

    // form feed: full clear and home
    push_blank_all();
    send_idle(8'h0C);
    chk("ff_busy", busy, 1);
    chk("ff_top", top_row, 0);
    chk("ff_cur_x", cur_x, 0);
    chk("ff_cur_y", cur_y, 0);
    wait_drain(cyc);
    chk("ff_clr_cycles", cyc, 2100);
    chk("ff_ready", ch_ready, 1);

    // 6: reset in the middle of a row clear
    for (int i = 0; i < ROWS - 1; i++) send_idle(8'h0A);
    chk("pre_abort_cur_y", cur_y, ROWS - 1);
    for (int i = 0; i < 30; i++) push(i, 0, 8'h20);
    send_idle(8'h0A);
    wait_drain(cyc);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    exp_q.delete();
    push_blank_all();
    step();
    step();
    reset = 1'b0;
    wait_drain(cyc);
    chk("abort_clr_cycles", cyc, 2100);
    chk("abort_ready", ch_ready, 1);
    chk("abort_top", top_row, 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
